// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the byte-stream handshake and the core fetch port of the
//   instruction-memory loader.
//   rx_data  [7:0]  stream byte            (master -> slave)
//   rx_valid        rx_data is valid       (master -> slave)
//   rx_ready        loader accepts a byte  (slave  -> master)
//   addr     [31:0] fetch byte address     (master -> slave)
//   data     [31:0] fetched instruction    (slave  -> master)
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] addr;
    logic [31:0] data;

    modport master (
        output rx_data,
        output rx_valid,
        output addr,
        input  rx_ready,
        input  data
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  addr,
        output rx_ready,
        output data
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Byte-stream programming front end and storage for the instruction memory.
//   A load is a header byte N followed by 4*N little-endian bytes; each group
//   of four bytes becomes one 32-bit word written to mem[0..N-1]. The core is
//   held in reset until a load completes. The fetch port is combinational.
//
//   Parameters:
//     DEPTH   words stored (1..255)
//     TIMEOUT inter-byte timeout in cycles (only with IMEM_LOADER_TIMEOUT_EN)
//   Ports:
//     clk        clock
//     reset      synchronous active-high reset (memory contents survive it)
//     start      one-cycle pulse starting a load (honoured in IDLE/DONE/ERR)
//     bus        imem_loader_if.slave: rx_data/rx_valid/rx_ready stream,
//                addr/data fetch port
//     cpu_reset  reset to the core, low only in DONE
//     done       load complete
//     err        load aborted (header too large, or inter-byte timeout)
//   Build option:
//     IMEM_LOADER_TIMEOUT_EN  when defined, DATA aborts to ERR after TIMEOUT
//                             cycles without a byte transfer.
module imem_loader #(
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         done,
    output logic         err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  widx_q, widx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [23:0] buf_q, buf_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    // Zero power-up contents; reset deliberately leaves the array alone.
    logic [31:0] mem_q [DEPTH] = '{default: '0};

    // rx_ready decodes from the state register, so the transfer condition
    // is formed from the state directly rather than from the output port.
    logic accepting;
    logic xfer;
    assign accepting = (state_q == S_HDR) || (state_q == S_DATA);
    assign xfer      = accepting && bus.rx_valid;

    logic last_word;
    assign last_word = (widx_q == (n_q - 8'd1));

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    // Expires on the TIMEOUT-th consecutive idle cycle in DATA.
    assign tmo_hit = (state_q == S_DATA) && !xfer && (tmo_q == TW'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            buf_q   <= buf_d;
        end
    end

`ifdef IMEM_LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    always_comb begin
        tmo_d = '0;
        // Clears on entry (state_q != S_DATA) and on every transfer.
        if (state_q == S_DATA && !xfer) begin
            tmo_d = tmo_q + TW'(1);
        end
    end
`endif

    // Word store; a write racing a reset edge belongs to an aborted load.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        widx_d    = widx_q;
        bidx_d    = bidx_q;
        buf_d     = buf_q;
        mem_we    = 1'b0;
        mem_waddr = widx_q[AW-1:0];
        mem_wdata = {bus.rx_data, buf_q};

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    n_d = bus.rx_data;
                    if (bus.rx_data == 8'd0) begin
                        state_d = S_DONE;
                    end else if (bus.rx_data > 8'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                        widx_d  = '0;
                        bidx_d  = '0;
                        buf_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    bidx_d = bidx_q + 2'd1;
                    unique case (bidx_q)
                        2'd0: buf_d[7:0]   = bus.rx_data;
                        2'd1: buf_d[15:8]  = bus.rx_data;
                        2'd2: buf_d[23:16] = bus.rx_data;
                        default: begin
                            // Fourth byte goes straight into the write data.
                            mem_we = 1'b1;
                            if (last_word) begin
                                state_d = S_DONE;
                            end else begin
                                widx_d = widx_q + 8'd1;
                            end
                        end
                    endcase
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from the state register only
    // ------------------------------------------------------------------
    always_comb begin
        bus.rx_ready = 1'b0;
        cpu_reset    = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
        unique case (state_q)
            S_HDR, S_DATA: bus.rx_ready = 1'b1;
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch port: word index from addr[31:2], zero beyond DEPTH
    // ------------------------------------------------------------------
    logic [29:0] rd_word;
    logic        unused_addr_lsb;
    assign rd_word         = bus.addr[31:2];
    assign unused_addr_lsb = ^bus.addr[1:0];

    always_comb begin
        bus.data = 32'h0000_0000;
        if (rd_word < 30'(DEPTH)) begin
            bus.data = mem_q[rd_word[AW-1:0]];
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programming front end and storage for the RISC-V instruction memory. Accepts a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words and writes them into an internal word array. Holds the core in reset until a load completes. Serves the core's combinational fetch port (`addr` → `data`) once loading is done.

## Interface
Parameters:
- `DEPTH`, 64: instruction words stored. Legal range 1..255.
- `TIMEOUT`, 1024: inter-byte timeout in cycles. Used only with `IMEM_LOADER_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins a load. Honoured only in IDLE, DONE and ERR.
- `rx_data`, in, 8: stream byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: loader accepts a byte. A byte transfers on a rising edge where `rx_valid & rx_ready` is high.
- `addr`, in, 32: core fetch byte address. Word index is `addr[31:2]`.
- `data`, out, 32: fetched instruction. Combinational.
- `cpu_reset`, out, 1: reset to the core. High in every state except DONE.
- `done`, out, 1: load complete.
- `err`, out, 1: load aborted.

## Operation
- FSM states: IDLE, HDR, DATA, DONE, ERR. All outputs decode directly from the state register.
  - IDLE: `rx_ready`=0. On `start` → HDR.
  - HDR: `rx_ready`=1. On a transfer, latch N=`rx_data`.
    - N==0 → DONE.
    - N>DEPTH → ERR.
    - Otherwise → DATA, with word index `widx`=0 and byte lane `bidx`=0.
  - DATA: `rx_ready`=1. Each transfer places the byte in lane `bidx` of the assembly buffer, little-endian (first byte is bits [7:0]), then increments `bidx` mod 4.
    - On the transfer with `bidx`==3, write `mem[widx]` = {`rx_data`, buf[23:0]} on that same edge, then increment `widx`.
    - If that write has `widx`==N-1 → DONE.
  - DONE: `done`=1, `cpu_reset`=0, `rx_ready`=0. On `start` → HDR (reload). `cpu_reset` returns high.
  - ERR: `err`=1, `cpu_reset`=1, `rx_ready`=0. On `start` → HDR. `err` clears.
- `start` is ignored in HDR and DATA.
- Read port: `data` = `mem[addr[31:2]]` when `addr[31:2]` < DEPTH, else 32'h0000_0000. The read path ignores `addr[1:0]`.
- Memory power-up contents are all zero. `reset` does not clear memory.
- Words with index ≥ N keep their previous contents after a load.

## Timing
- Reset values: state IDLE, `rx_ready`=0, `cpu_reset`=1, `done`=0, `err`=0, `widx`=0, `bidx`=0. The assembly buffer is cleared.
- `reset` asserted mid-load: return to IDLE on that edge.
  - Words already written are retained.
  - A partially assembled word is discarded.
- Throughput: one byte per cycle with `rx_valid` held high. Bubbles on `rx_valid` are allowed at any point.
- Latency from the final byte's transfer edge:
  - `done`=1 and `cpu_reset`=0 in the following cycle.
  - The written word is visible on `data` in the following cycle.
- N==0: `done` is high in the cycle after the header transfer.
- N>DEPTH: `err` is high in the cycle after the header transfer, and no write occurs.
- N==DEPTH: the last write hits `mem[DEPTH-1]`. No wrap-around, and `widx` never exceeds N-1.
- Bytes presented in IDLE, DONE or ERR are not accepted, because `rx_ready`=0.

## Configuration
- `IMEM_LOADER_TIMEOUT_EN` defined:
  - A counter runs while in DATA.
  - The counter clears on each transfer and on DATA entry.
  - When the counter reaches TIMEOUT cycles without a transfer → ERR. Words already written are retained.
- `IMEM_LOADER_TIMEOUT_EN` undefined: no counter is built and DATA waits indefinitely. `TIMEOUT` is unused.

## Test plan
- Basic load: reset, `start`, bytes 02, 13 01 40 00, 33 02 11 00 at one per cycle.
  - Required: `mem[0]`=32'h0040_0113 and `mem[1]`=32'h0011_0233.
  - Required: `done`=1 and `cpu_reset`=0 one cycle after the last byte.
  - Required: `addr`=4 gives `data`=32'h0011_0233, and `addr`=32'h100 gives 0.
- Bubbled stream: same bytes with `rx_valid` low for 3 cycles between each byte → identical memory and flags. `rx_ready` stays 1 throughout DATA.
- Header edge cases:
  - Header 00 → `done`=1 next cycle and memory unchanged.
  - Header 65 (DEPTH=64) → `err`=1, `cpu_reset`=1, no writes. A subsequent `start` plus header 01 and 4 bytes → `done`=1 and `err`=0.
- Reset mid-load: header 02 plus 5 data bytes, then assert `reset` for 1 cycle.
  - Required: state IDLE, `cpu_reset`=1, `done`=0.
  - Required: `mem[0]` keeps the loaded word and `mem[1]` is unchanged.
  - Required: a new load starts cleanly at `widx`=0.
- Reload from DONE: `start` in DONE → `cpu_reset`=1 the next cycle. Load header 01 with bytes 93 00 50 00 → `mem[0]`=32'h0050_0093.
- Timeout: stall 1024 cycles in DATA after 2 bytes.
  - With `IMEM_LOADER_TIMEOUT_EN`: `err`=1.
  - Without it: still in DATA after 2000 cycles, and a resumed stream completes normally.
